// File: rtl/fib_seq_gen.sv
// fib_seq_gen
//   Fibonacci-sequence engine. After an accepted start it steps
//   F(k) = F(k-1) + F(k-2) once per clock from seeds F(0)=f0 and F(1)=f1,
//   streams every term F(2)..F(n) and reports F(n) with a done pulse.
//   On carry out of the WIDTH-bit sum, the sticky ovf flag is set. The
//   result then wraps (SAT=0) or saturates to all-ones (SAT=1).
//
// Parameters
//   WIDTH : width of seeds, terms and result
//   IDX_W : width of the target index n
//   SAT   : 0 = wrap modulo 2^WIDTH, 1 = saturate to all-ones
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   run request, honoured only while idle
//   f0, f1     in   seeds F(0), F(1), captured on an accepted start
//   n          in   target index, captured on an accepted start
//   busy       out  high while terms are being computed
//   done       out  one-cycle pulse, fn valid in that cycle
//   fn         out  F(n), held until the next done
//   term_valid out  one-cycle pulse per streamed term
//   term       out  streamed term F(k), k = 2..n
//   ovf        out  sticky overflow flag for the current or last run
module fib_seq_gen #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 6,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] f0,
  input  logic [WIDTH-1:0] f1,
  input  logic [IDX_W-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] fn,
  output logic             term_valid,
  output logic [WIDTH-1:0] term,
  output logic             ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] n_reg_q, n_reg_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] fn_q, fn_d;
  logic             term_valid_q, term_valid_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;

  // Carry out selects between wrap and saturation. Once a term is all-ones
  // in SAT mode, every later sum carries (or adds zero), so it stays there.
  function automatic logic [WIDTH-1:0] limit_sum(input logic [WIDTH:0] s);
    if (s[WIDTH] && (SAT != 0)) begin
      return {WIDTH{1'b1}};
    end
    return s[WIDTH-1:0];
  endfunction

  // Stage: combinational recurrence step
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign result = limit_sum(sum);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    n_reg_d      = n_reg_q;
    cnt_d        = cnt_q;
    fn_d         = fn_q;
    term_d       = term_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    term_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = f0;
          b_d     = f1;
          n_reg_d = n;
          cnt_d   = IDX_W'(2);
          ovf_d   = 1'b0;
          // Trivial indices complete straight from the seeds.
          if (n == IDX_W'(0)) begin
            done_d = 1'b1;
            fn_d   = f0;
          end else if (n == IDX_W'(1)) begin
            done_d = 1'b1;
            fn_d   = f1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (sum[WIDTH]) begin
          ovf_d = 1'b1;
        end
        a_d          = b_q;
        b_d          = result;
        term_d       = result;
        term_valid_d = 1'b1;
        if (cnt_q == n_reg_q) begin
          fn_d    = result;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // busy is registered, so it tracks the state being entered.
    busy_d = (state_d == RUN);
  end

  // Stage: registered control and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fn_q         <= '0;
      term_valid_q <= 1'b0;
      term_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fn_q         <= fn_d;
      term_valid_q <= term_valid_d;
      term_q       <= term_d;
      ovf_q        <= ovf_d;
    end
  end

  // Stage: working registers, always rewritten on an accepted start
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    n_reg_q <= n_reg_d;
    cnt_q   <= cnt_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fn         = fn_q;
  assign term_valid = term_valid_q;
  assign term       = term_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: the stimulus process pushes expected
// terms and done events (value, ovf, cycle) into queues; a monitor on the
// falling edge pops and compares whenever term_valid or done is seen.
module tb_fib_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_s = 1'b0;
  logic [7:0] f0 = '0;
  logic [7:0] f1 = '0;
  logic [5:0] n = '0;
  logic       busy, done, term_valid, ovf;
  logic [7:0] fn, term;
  logic       busy_s, done_s, term_valid_s, ovf_s;
  logic [7:0] fn_s, term_s;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(8), .IDX_W(6), .SAT(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .f0(f0), .f1(f1), .n(n),
    .busy(busy), .done(done), .fn(fn), .term_valid(term_valid),
    .term(term), .ovf(ovf)
  );

  fib_seq_gen #(.WIDTH(8), .IDX_W(6), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .f0(f0), .f1(f1), .n(n),
    .busy(busy_s), .done(done_s), .fn(fn_s), .term_valid(term_valid_s),
    .term(term_s), .ovf(ovf_s)
  );

  typedef struct {
    logic [7:0] v;
    logic       o;
    int         c;
  } ev_t;

  ev_t tq[$];
  ev_t dq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  busy_lo = -1;
  int  busy_hi = -2;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_t(input logic [7:0] v, input logic o, input int c);
    ev_t e;
    e.v = v; e.o = o; e.c = c;
    tq.push_back(e);
  endtask

  task automatic push_d(input logic [7:0] v, input logic o, input int c);
    ev_t e;
    e.v = v; e.o = o; e.c = c;
    dq.push_back(e);
  endtask

  // Drive a start in the next cycle; t returns that cycle (T).
  task automatic start_run(input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] nn, output int t);
    @(posedge clk);
    #1;
    f0 = a; f1 = b; n = nn; start = 1'b1;
    t = cyc;
    if (nn >= 2) begin
      busy_lo = t + 1;
      busy_hi = t + int'(nn) - 1;
    end else begin
      busy_lo = -1;
      busy_hi = -2;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (tq.size() != 0 || dq.size() != 0); i++)
      @(negedge clk);
    chk("queue_drain", tq.size() + dq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (term_valid) begin
        if (tq.size() == 0) begin
          chk("unexpected_term", 1, 0);
        end else begin
          ev_t e;
          e = tq.pop_front();
          chk("term_val", int'(term), int'(e.v));
          chk("term_cyc", cyc, e.c);
          chk("term_ovf", int'(ovf), int'(e.o));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ev_t e;
          e = dq.pop_front();
          chk("done_fn", int'(fn), int'(e.v));
          chk("done_cyc", cyc, e.c);
          chk("done_ovf", int'(ovf), int'(e.o));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic [7:0] fib10 [9];
    logic [7:0] fib14 [13];
    logic [7:0] last_s;
    int got_s, dc_s, fn_sv, ovf_sv;

    fib10 = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55};
    fib14 = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55,
              8'd89, 8'd144, 8'd233, 8'd121};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fn", int'(fn), 0);
    chk("rst_term_valid", int'(term_valid), 0);
    chk("rst_term", int'(term), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_sat_fn", int'(fn_s), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // n=10 from 0,1
    start_run(8'd0, 8'd1, 6'd10, t);
    for (int k = 0; k < 9; k++) push_t(fib10[k], 1'b0, t + 2 + k);
    push_d(8'd55, 1'b0, t + 10);
    drain(40);

    // n=14 wraps on the last term
    start_run(8'd0, 8'd1, 6'd14, t);
    for (int k = 0; k < 13; k++) push_t(fib14[k], (k == 12), t + 2 + k);
    push_d(8'd121, 1'b1, t + 14);
    drain(40);

    // n=0 clears ovf and returns f0
    start_run(8'd7, 8'd33, 6'd0, t);
    push_d(8'd7, 1'b0, t + 1);
    drain(10);

    // n=1 returns f1
    start_run(8'd4, 8'd9, 6'd1, t);
    push_d(8'd9, 1'b0, t + 1);
    drain(10);

    // n=5 from 2,3 with an ignored start and a back-to-back start
    start_run(8'd2, 8'd3, 6'd5, t);
    push_t(8'd5, 1'b0, t + 2);
    push_t(8'd8, 1'b0, t + 3);
    push_t(8'd13, 1'b0, t + 4);
    push_t(8'd21, 1'b0, t + 5);
    push_d(8'd21, 1'b0, t + 5);
    @(posedge clk);
    #1;
    f0 = 8'd100; f1 = 8'd100; n = 6'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    start_run(8'd1, 8'd1, 6'd2, t);
    chk("b2b_cycle", t, busy_lo - 1);
    push_t(8'd2, 1'b0, t + 2);
    push_d(8'd2, 1'b0, t + 2);
    drain(20);

    // n=20 aborted by reset in T+6
    start_run(8'd0, 8'd1, 6'd20, t);
    for (int k = 0; k < 5; k++) push_t(fib10[k], 1'b0, t + 2 + k);
    busy_hi = t + 6;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_fn", int'(fn), 0);
    chk("abort_term", int'(term), 0);
    chk("abort_ovf", int'(ovf), 0);
    repeat (20) @(negedge clk);
    chk("abort_quiet", tq.size() + dq.size(), 0);

    // Fresh run after the abort
    start_run(8'd4, 8'd5, 6'd3, t);
    push_t(8'd9, 1'b0, t + 2);
    push_t(8'd14, 1'b0, t + 3);
    push_d(8'd14, 1'b0, t + 3);
    drain(20);

    // Saturating instance, n=14 from 0,1
    @(posedge clk);
    #1;
    f0 = 8'd0; f1 = 8'd1; n = 6'd14; start_s = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    got_s = 0; dc_s = 0; fn_sv = 0; ovf_sv = 0; last_s = '0;
    for (int i = 0; i < 40 && got_s == 0; i++) begin
      @(negedge clk);
      if (done_s) begin
        got_s = 1; dc_s = cyc; fn_sv = int'(fn_s); ovf_sv = int'(ovf_s);
      end else if (term_valid_s) begin
        last_s = term_s;
      end
    end
    chk("sat_done_seen", got_s, 1);
    chk("sat_done_cyc", dc_s, t + 14);
    chk("sat_fn", fn_sv, 255);
    chk("sat_ovf", ovf_sv, 1);
    chk("sat_prev_term", int'(last_s), 233);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
